// File: rtl/apu_pkg.sv
// ---------------------------------------------------------------------------
// apu_pkg
// Shared types and constants for the APU delta-modulation channel controller.
//   reader_state_t   : sample memory reader states (IDLE / REQ)
//   DMC_REG_*        : reg_sel encodings for $4010..$4013
//   DMC_ADDR_WRAP    : address the reader continues from after $FFFF
//   DMC_BYTES_W      : width of the bytes-remaining counter
//   dmc_next_addr()  : sample address increment with the $FFFF -> $8000 wrap
// ---------------------------------------------------------------------------
package apu_pkg;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_REQ  = 1'b1
  } reader_state_t;

  localparam logic [1:0]  DMC_REG_CTRL  = 2'd0;  // $4010
  localparam logic [1:0]  DMC_REG_LOAD  = 2'd1;  // $4011
  localparam logic [1:0]  DMC_REG_ADDR  = 2'd2;  // $4012
  localparam logic [1:0]  DMC_REG_LEN   = 2'd3;  // $4013

  localparam logic [15:0] DMC_ADDR_WRAP = 16'h8000;
  localparam int          DMC_BYTES_W   = 12;

  // Sample fetches never leave cartridge space: $FFFF is followed by $8000.
  function automatic logic [15:0] dmc_next_addr(input logic [15:0] addr);
    logic [15:0] nxt;
    if (addr == 16'hFFFF) nxt = DMC_ADDR_WRAP;
    else                  nxt = addr + 16'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/dmc_controller_if.sv
// ---------------------------------------------------------------------------
// dmc_controller_if
// DMA byte-fetch port between the DMC sample reader and the memory arbiter.
//   dma_req   : reader wants a byte
//   dma_addr  : address of the wanted byte
//   dma_ack   : byte delivered this cycle (meaningful only while dma_req=1)
//   dma_rdata : delivered byte
// master = DMC controller, slave = memory side.
// ---------------------------------------------------------------------------
interface dmc_controller_if;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_rdata;

  modport master (output dma_req, output dma_addr, input dma_ack, input dma_rdata);
  modport slave  (input dma_req, input dma_addr, output dma_ack, output dma_rdata);
endinterface

// File: rtl/dmc_output_unit.sv
// ---------------------------------------------------------------------------
// dmc_output_unit
// 1-bit delta output unit: plays the shift register one bit per step,
// nudging the 7-bit level up/down by LEVEL_STEP without wrapping, and pulls
// the next byte out of the sample buffer every 8 steps.
//   clk, reset_n : clock, async active-low reset
//   step         : advance one output bit (already qualified by cpu_en)
//   load         : direct level load ($4011), wins over a same-cycle step
//   load_value   : value for the direct load
//   buf_full     : sample buffer holds a byte
//   buf_data     : sample buffer contents
//   buf_take     : buffer byte consumed this cycle
//   level        : registered channel level
// ---------------------------------------------------------------------------
module dmc_output_unit #(
  parameter int LEVEL_STEP = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  input  logic       load,
  input  logic [6:0] load_value,
  input  logic       buf_full,
  input  logic [7:0] buf_data,
  output logic       buf_take,
  output logic [6:0] level
);

  localparam logic [6:0] LEVEL_INC  = 7'(LEVEL_STEP);
  localparam logic [6:0] LEVEL_CEIL = 7'(127 - LEVEL_STEP);

  logic [7:0] shift_r, shift_nx_s;
  logic [2:0] bit_cnt_r, bit_cnt_nx_s;
  logic       silence_r, silence_nx_s;
  logic [6:0] level_r, step_level_s, level_nx_s;

  // Next bit / level computation for one output step.
  always_comb begin
    shift_nx_s   = shift_r;
    bit_cnt_nx_s = bit_cnt_r;
    silence_nx_s = silence_r;
    step_level_s = level_r;
    buf_take     = 1'b0;
    if (step) begin
      if (!silence_r && shift_r[0] && (level_r <= LEVEL_CEIL)) begin
        step_level_s = level_r + LEVEL_INC;
      end else if (!silence_r && !shift_r[0] && (level_r >= LEVEL_INC)) begin
        step_level_s = level_r - LEVEL_INC;
      end else begin
        step_level_s = level_r;
      end
      if (bit_cnt_r != 3'd0) begin
        shift_nx_s   = {1'b0, shift_r[7:1]};
        bit_cnt_nx_s = bit_cnt_r - 3'd1;
        silence_nx_s = silence_r;
      end else if (buf_full) begin
        // End of an output cycle with a byte waiting: start playing it.
        shift_nx_s   = buf_data;
        bit_cnt_nx_s = 3'd7;
        silence_nx_s = 1'b0;
        buf_take     = 1'b1;
      end else begin
        shift_nx_s   = {1'b0, shift_r[7:1]};
        bit_cnt_nx_s = 3'd7;
        silence_nx_s = 1'b1;
      end
    end else begin
      step_level_s = level_r;
    end
  end

  assign level_nx_s = load ? load_value : step_level_s;

  // Output unit state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd7;
      silence_r <= 1'b1;
      level_r   <= 7'd0;
    end else begin
      shift_r   <= shift_nx_s;
      bit_cnt_r <= bit_cnt_nx_s;
      silence_r <= silence_nx_s;
      level_r   <= level_nx_s;
    end
  end

  assign level = level_r;

endmodule

// File: rtl/dmc_controller.sv
// ---------------------------------------------------------------------------
// dmc_controller
// Delta-modulation channel sequencer: register decode ($4010-$4013, $4015),
// sample memory reader over a DMA req/ack port, output unit, IRQ and status.
//   clk, reset_n            : clock, async active-low reset
//   cpu_en                  : CPU-cycle enable, gates every state change
//   reg_wr/reg_sel/reg_wdata: $4010-$4013 write port
//   status_wr/status_en     : $4015 write strobe and its DMC enable bit
//   next_step               : rate timer expiry pulse
//   timer_set/timer_index   : rate reload towards the external timer
//   dma                     : byte fetch port (master side)
//   level                   : 7-bit channel level
//   active                  : sample bytes still to fetch
//   irq                     : DMC interrupt flag
// ---------------------------------------------------------------------------
module dmc_controller
  import apu_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE  = 16'hC000,
  parameter int          LEVEL_STEP = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_en,
  input  logic             reg_wr,
  input  logic [1:0]       reg_sel,
  input  logic [7:0]       reg_wdata,
  input  logic             status_wr,
  input  logic             status_en,
  input  logic             next_step,
  output logic             timer_set,
  output logic [3:0]       timer_index,
  dmc_controller_if.master dma,
  output logic [6:0]       level,
  output logic             active,
  output logic             irq
);

  reader_state_t          state_r, state_nx_s;
  logic [15:0]            addr_r, addr_nx_s;
  logic [DMC_BYTES_W-1:0] bytes_rem_r, bytes_rem_nx_s;
  logic [7:0]             buf_r, buf_nx_s;
  logic                   buf_full_r, buf_full_nx_s;
  logic                   irq_r, irq_nx_s;
  logic                   active_r;
  logic                   irq_en_r, loop_r;
  logic [7:0]             a_r, l_r;

  logic ctrl_wr_s, load_wr_s, addr_wr_s, len_wr_s;
  logic dis_s, en_wr_s, ack_s, buf_take_s;
  logic [15:0]            start_addr_s;
  logic [DMC_BYTES_W-1:0] start_len_s;

  assign ctrl_wr_s = cpu_en && reg_wr && (reg_sel == DMC_REG_CTRL);
  assign load_wr_s = cpu_en && reg_wr && (reg_sel == DMC_REG_LOAD);
  assign addr_wr_s = cpu_en && reg_wr && (reg_sel == DMC_REG_ADDR);
  assign len_wr_s  = cpu_en && reg_wr && (reg_sel == DMC_REG_LEN);
  assign dis_s     = cpu_en && status_wr && !status_en;
  assign en_wr_s   = cpu_en && status_wr && status_en;
  // An ack landing in the same cycle as a disable is dropped with the fetch.
  assign ack_s     = cpu_en && (state_r == RD_REQ) && dma.dma_ack && !dis_s;

  assign start_addr_s = ADDR_BASE + {2'b00, a_r, 6'b000000};
  assign start_len_s  = {l_r, 4'b0000} + 12'd1;

  assign timer_set   = ctrl_wr_s;
  assign timer_index = reg_wdata[3:0];

  // Reader state transitions.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (cpu_en && !dis_s && !buf_full_r && (bytes_rem_r != 12'd0)) state_nx_s = RD_REQ;
        else                                                            state_nx_s = RD_IDLE;
      end
      RD_REQ: begin
        if (dis_s || ack_s) state_nx_s = RD_IDLE;
        else                state_nx_s = RD_REQ;
      end
      default: state_nx_s = RD_IDLE;
    endcase
  end

  // Sample buffer, address, byte count and IRQ updates.
  always_comb begin
    addr_nx_s      = addr_r;
    bytes_rem_nx_s = bytes_rem_r;
    buf_nx_s       = buf_r;
    buf_full_nx_s  = buf_full_r;
    irq_nx_s       = irq_r;
    if (ack_s) begin
      buf_nx_s       = dma.dma_rdata;
      buf_full_nx_s  = 1'b1;
      addr_nx_s      = dmc_next_addr(addr_r);
      bytes_rem_nx_s = bytes_rem_r - 12'd1;
      if (bytes_rem_r == 12'd1) begin
        if (loop_r) begin
          addr_nx_s      = start_addr_s;
          bytes_rem_nx_s = start_len_s;
        end else if (irq_en_r) begin
          irq_nx_s = 1'b1;
        end else begin
          irq_nx_s = irq_r;
        end
      end else begin
        irq_nx_s = irq_r;
      end
    end else if (buf_take_s) begin
      buf_full_nx_s = 1'b0;
    end else begin
      buf_full_nx_s = buf_full_r;
    end
    // A running sample (bytes_rem != 0) ignores a repeated enable.
    if (dis_s) begin
      bytes_rem_nx_s = {DMC_BYTES_W{1'b0}};
    end else if (en_wr_s && (bytes_rem_r == 12'd0)) begin
      addr_nx_s      = start_addr_s;
      bytes_rem_nx_s = start_len_s;
    end else begin
      bytes_rem_nx_s = bytes_rem_nx_s;
    end
    if (cpu_en && status_wr)           irq_nx_s = 1'b0;
    else if (ctrl_wr_s && !reg_wdata[7]) irq_nx_s = 1'b0;
    else                               irq_nx_s = irq_nx_s;
  end

  // Reader and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= RD_IDLE;
      addr_r      <= ADDR_BASE;
      bytes_rem_r <= {DMC_BYTES_W{1'b0}};
      buf_r       <= 8'h00;
      buf_full_r  <= 1'b0;
      irq_r       <= 1'b0;
      active_r    <= 1'b0;
    end else if (cpu_en) begin
      state_r     <= state_nx_s;
      addr_r      <= addr_nx_s;
      bytes_rem_r <= bytes_rem_nx_s;
      buf_r       <= buf_nx_s;
      buf_full_r  <= buf_full_nx_s;
      irq_r       <= irq_nx_s;
      active_r    <= (bytes_rem_nx_s != 12'd0);
    end
  end

  // Configuration registers; A and L are only used at the next (re)start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_r <= 1'b0;
      loop_r   <= 1'b0;
      a_r      <= 8'h00;
      l_r      <= 8'h00;
    end else begin
      if (ctrl_wr_s) begin
        irq_en_r <= reg_wdata[7];
        loop_r   <= reg_wdata[6];
      end
      if (addr_wr_s) a_r <= reg_wdata;
      if (len_wr_s)  l_r <= reg_wdata;
    end
  end

  dmc_output_unit #(
    .LEVEL_STEP (LEVEL_STEP)
  ) u_output (
    .clk        (clk),
    .reset_n    (reset_n),
    .step       (cpu_en && next_step),
    .load       (load_wr_s),
    .load_value (reg_wdata[6:0]),
    .buf_full   (buf_full_r),
    .buf_data   (buf_r),
    .buf_take   (buf_take_s),
    .level      (level)
  );

  assign dma.dma_req  = (state_r == RD_REQ);
  assign dma.dma_addr = addr_r;
  assign active       = active_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_dmc_controller.sv
// ---------------------------------------------------------------------------
// tb_dmc_controller
// Directed scenarios followed by a randomized phase. A behavioural model of
// the channel (plain integers: level, bytes left, pending fetch, buffered
// byte, bits still to play) predicts every output after each clock.
// ---------------------------------------------------------------------------
module tb_dmc_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_en = 1'b1;
  logic       reg_wr = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] reg_wdata = 8'h00;
  logic       status_wr = 1'b0;
  logic       status_en = 1'b0;
  logic       next_step = 1'b0;
  logic       timer_set;
  logic [3:0] timer_index;
  logic [6:0] level;
  logic       active;
  logic       irq;

  dmc_controller_if dma_bus ();

  dmc_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_en      (cpu_en),
    .reg_wr      (reg_wr),
    .reg_sel     (reg_sel),
    .reg_wdata   (reg_wdata),
    .status_wr   (status_wr),
    .status_en   (status_en),
    .next_step   (next_step),
    .timer_set   (timer_set),
    .timer_index (timer_index),
    .dma         (dma_bus),
    .level       (level),
    .active      (active),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_level, m_rem, m_addr, m_buf, m_bits, m_cnt, m_a, m_l;
  bit m_irq, m_req, m_full, m_sil, m_irq_en, m_loop;

  logic [15:0] ack_addrs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_rem = 0; m_addr = 'hC000; m_buf = 0; m_bits = 0; m_cnt = 7;
    m_a = 0; m_l = 0; m_irq = 0; m_req = 0; m_full = 0; m_sil = 1;
    m_irq_en = 0; m_loop = 0;
  endtask

  task automatic model_start();
    m_addr = 'hC000 + m_a * 64;
    m_rem  = m_l * 16 + 1;
  endtask

  // One clock: predict, clock, compare, then drop the one-shot strobes.
  task automatic tick();
    bit dis, ack_eff, old_full;
    int old_rem;
    #1;
    chk("timer_set", timer_set, cpu_en && reg_wr && reg_sel == 2'd0);
    if (cpu_en && reg_wr && reg_sel == 2'd0) chk("timer_index", timer_index, reg_wdata[3:0]);
    if (cpu_en) begin
      old_full = m_full;
      old_rem  = m_rem;
      dis      = status_wr && !status_en;
      ack_eff  = m_req && dma_bus.dma_ack && !dis;
      if (next_step) begin
        if (!m_sil) begin
          if (m_bits % 2 == 1) m_level = (m_level + 2 > 127) ? m_level : m_level + 2;
          else                 m_level = (m_level < 2) ? m_level : m_level - 2;
        end
        m_bits = m_bits / 2;
        if (m_cnt > 0) m_cnt--;
        else begin
          m_cnt = 7;
          if (old_full) begin m_bits = m_buf; m_full = 0; m_sil = 0; end
          else m_sil = 1;
        end
      end
      if (reg_wr && reg_sel == 2'd1) m_level = reg_wdata % 128;
      if (dis) begin
        m_rem = 0; m_req = 0;
      end else if (ack_eff) begin
        m_buf = dma_bus.dma_rdata; m_full = 1; m_req = 0;
        m_addr = (m_addr == 'hFFFF) ? 'h8000 : m_addr + 1;
        m_rem--;
        if (m_rem == 0) begin
          if (m_loop) model_start();
          else if (m_irq_en) m_irq = 1;
        end
      end else if (!m_req && !old_full && old_rem != 0) begin
        m_req = 1;
      end
      if (status_wr && status_en && old_rem == 0) model_start();
      if (status_wr) m_irq = 0;
      if (reg_wr && reg_sel == 2'd0 && !reg_wdata[7]) m_irq = 0;
      if (reg_wr && reg_sel == 2'd0) begin m_irq_en = reg_wdata[7]; m_loop = reg_wdata[6]; end
      if (reg_wr && reg_sel == 2'd2) m_a = reg_wdata;
      if (reg_wr && reg_sel == 2'd3) m_l = reg_wdata;
    end
    @(posedge clk);
    #1;
    chk("level", level, m_level);
    chk("irq", irq, m_irq);
    chk("active", active, m_rem != 0);
    chk("dma_req", dma_bus.dma_req, m_req);
    chk("dma_addr", dma_bus.dma_addr, m_addr);
    reg_wr = 1'b0; status_wr = 1'b0; next_step = 1'b0;
    dma_bus.dma_ack = 1'b0; cpu_en = 1'b1;
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [7:0] d);
    reg_wr = 1'b1; reg_sel = sel; reg_wdata = d;
    tick();
  endtask

  task automatic wr_status(input logic en);
    status_wr = 1'b1; status_en = en;
    tick();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      next_step = 1'b1;
      tick();
    end
  endtask

  // Step and ack continuously until the sample is fully fetched (or limit).
  task automatic play(input logic [7:0] val, input int limit, output int n_acks);
    n_acks = 0;
    ack_addrs.delete();
    for (int i = 0; i < limit; i++) begin
      if (m_rem == 0 && !m_req) break;
      next_step = 1'b1; dma_bus.dma_ack = 1'b1; dma_bus.dma_rdata = val;
      if (dma_bus.dma_req === 1'b1) begin
        n_acks++;
        ack_addrs.push_back(dma_bus.dma_addr);
      end
      tick();
    end
  endtask

  initial begin
    int n;
    int r;
    logic [15:0] want_addr;
    dma_bus.dma_ack = 1'b0;
    dma_bus.dma_rdata = 8'h00;
    model_reset();

    // Reset values
    #12;
    chk("rst_level", level, 7'd0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_req", dma_bus.dma_req, 1'b0);
    chk("rst_active", active, 1'b0);
    chk("rst_addr", dma_bus.dma_addr, 16'hC000);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single fetch at A=1, L=0, then play it out
    wr_reg(2'd2, 8'h01);
    wr_reg(2'd3, 8'h00);
    wr_status(1'b1);
    chk("fetch_active", active, 1'b1);
    tick();
    chk("fetch_req", dma_bus.dma_req, 1'b1);
    chk("fetch_addr", dma_bus.dma_addr, 16'hC040);
    dma_bus.dma_ack = 1'b1; dma_bus.dma_rdata = 8'hFF;
    tick();
    chk("fetch_done_active", active, 1'b0);
    chk("fetch_done_req", dma_bus.dma_req, 1'b0);
    steps(8);
    chk("level_before_play", level, 7'd0);
    steps(8);
    chk("level_after_byte", level, 7'd16);
    steps(4);
    chk("level_hold_empty", level, 7'd16);

    // IRQ after 17 bytes, cleared by $4015 write and by $4010 bit7=0
    wr_reg(2'd0, 8'h80);
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd3, 8'h01);
    wr_status(1'b1);
    play(8'h5A, 400, n);
    chk("irq_ack_count", n, 17);
    chk("irq_set", irq, 1'b1);
    wr_status(1'b0);
    chk("irq_clr_4015", irq, 1'b0);
    wr_reg(2'd3, 8'h00);
    wr_status(1'b1);
    play(8'h55, 200, n);
    chk("irq_ack_count2", n, 1);
    chk("irq_set2", irq, 1'b1);
    wr_reg(2'd0, 8'h00);
    chk("irq_clr_4010", irq, 1'b0);

    // Loop mode: every fetch restarts at $C000
    wr_reg(2'd0, 8'h40);
    wr_status(1'b1);
    play(8'h0F, 80, n);
    chk("loop_has_acks", n >= 4, 1'b1);
    foreach (ack_addrs[k]) chk("loop_addr", ack_addrs[k], 16'hC000);
    chk("loop_active", active, 1'b1);
    chk("loop_irq", irq, 1'b0);
    wr_status(1'b0);
    wr_reg(2'd0, 8'h00);
    steps(24);

    // Address wrap: 65 bytes from $FFC0, the last one at $8000
    wr_reg(2'd2, 8'hFF);
    wr_reg(2'd3, 8'h04);
    wr_status(1'b1);
    play(8'hAA, 1200, n);
    chk("wrap_ack_count", n, 65);
    foreach (ack_addrs[k]) begin
      want_addr = (k < 64) ? 16'hFFC0 + 16'(k) : 16'h8000;
      chk("wrap_addr", ack_addrs[k], want_addr);
    end
    steps(24);

    // Clamp at the top and bottom, then $4011 priority over a step
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd3, 8'h00);
    wr_reg(2'd1, 8'd126);
    wr_status(1'b1);
    play(8'hFF, 50, n);
    steps(24);
    chk("clamp_high", level, 7'd126);
    wr_reg(2'd1, 8'd1);
    wr_status(1'b1);
    play(8'h00, 50, n);
    steps(24);
    chk("clamp_low", level, 7'd1);
    wr_reg(2'd1, 8'd50);
    wr_status(1'b1);
    play(8'hFF, 50, n);
    for (int i = 0; i < 40; i++) begin
      if (!m_sil) break;
      next_step = 1'b1;
      tick();
    end
    chk("prio_playing", level, 7'd50);
    next_step = 1'b1; reg_wr = 1'b1; reg_sel = 2'd1; reg_wdata = 8'h21;
    tick();
    chk("prio_load", level, 7'h21);
    steps(24);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      cpu_en = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        reg_wr = 1'b1; reg_sel = 2'($urandom_range(0, 3)); reg_wdata = 8'($urandom);
        if (reg_sel == 2'd3) reg_wdata = reg_wdata & 8'h03;
      end else if (r == 1) begin
        status_wr = 1'b1; status_en = ($urandom_range(0, 3) != 0);
      end
      next_step = ($urandom_range(0, 2) == 0);
      dma_bus.dma_ack = 1'($urandom_range(0, 1));
      dma_bus.dma_rdata = 8'($urandom);
      tick();
    end

    // Asynchronous reset in the middle of a fetch
    wr_status(1'b0);
    wr_reg(2'd0, 8'h00);
    wr_reg(2'd1, 8'h55);
    wr_reg(2'd3, 8'h10);
    steps(24);
    wr_status(1'b1);
    tick();
    chk("pre_reset_req", dma_bus.dma_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_req", dma_bus.dma_req, 1'b0);
    chk("async_rst_level", level, 7'd0);
    chk("async_rst_irq", irq, 1'b0);
    chk("async_rst_active", active, 1'b0);
    model_reset();
    reset_n = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
